// File: rtl/disp_fetch_if.sv
// rtl/disp_fetch_if.sv - AXI read channel and display-buffer signal bundle for disp_fetch
interface disp_fetch_if;
  logic        DISPON;
  logic        VSTART;
  logic [31:0] DISPADDR;
  logic        BUF_WREADY;
  logic        FIFORST;
  logic [63:0] FIFOIN;
  logic        FIFOWR;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic        RVALID;
  logic        RLAST;
  logic        RREADY;

  modport master (
    input  DISPON, VSTART, DISPADDR, BUF_WREADY, ARREADY, RDATA, RVALID, RLAST,
    output FIFORST, FIFOIN, FIFOWR, ARADDR, ARLEN, ARVALID, RREADY
  );

  modport slave (
    output DISPON, VSTART, DISPADDR, BUF_WREADY, ARREADY, RDATA, RVALID, RLAST,
    input  FIFORST, FIFOIN, FIFOWR, ARADDR, ARLEN, ARVALID, RREADY
  );
endinterface

// File: rtl/disp_fetch.sv
// rtl/disp_fetch.sv - AXI4 burst read master filling the display FIFO from the framebuffer
module disp_fetch #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int BURST_LEN  = 16,
  parameter int BEAT_BYTES = 8
) (
  input  logic         ACLK,
  input  logic         ARST,
  disp_fetch_if.master bus
);
  localparam int WORDS  = H_PIXELS * V_LINES / 2;
  localparam int NBURST = WORDS / BURST_LEN;
  localparam int CNT_W  = $clog2(NBURST + 1);
  localparam logic [31:0]      STEP     = 32'(BURST_LEN * BEAT_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBURST);

  localparam logic [2:0] HALT    = 3'd0;
  localparam logic [2:0] FLUSH   = 3'd1;
  localparam logic [2:0] WAITBUF = 3'd2;
  localparam logic [2:0] ADDR    = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;

  logic [2:0]       state;
  logic [31:0]      araddr_q;
  logic             arvalid_q;
  logic             rready_q;
  logic             fifowr_q;
  logic             fiforst_q;
  logic [63:0]      fifoin_q;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             pending;
  logic             beat_ok;
  logic             last_beat;

  assign beat_ok   = (state == DATA) && rready_q && bus.RVALID;
  assign last_beat = beat_ok && bus.RLAST;
  assign cnt_inc   = burst_cnt + CNT_W'(1);

  assign bus.ARADDR  = araddr_q;
  assign bus.ARLEN   = 8'(BURST_LEN - 1);
  assign bus.ARVALID = arvalid_q;
  assign bus.RREADY  = rready_q;
  assign bus.FIFOWR  = fifowr_q;
  assign bus.FIFOIN  = fifoin_q;
  assign bus.FIFORST = fiforst_q;

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state     <= HALT;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      fifowr_q  <= 1'b0;
      fiforst_q <= 1'b0;
      fifoin_q  <= '0;
      burst_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      fifowr_q <= beat_ok;
      if (beat_ok) fifoin_q <= bus.RDATA;
      // Flush pulse trails the FLUSH state by a cycle so it lands after the final old-frame write.
      fiforst_q <= (state == FLUSH);

      case (state)
        HALT: begin
          if (bus.VSTART && bus.DISPON) begin
            araddr_q  <= bus.DISPADDR;
            burst_cnt <= '0;
            state     <= FLUSH;
          end
        end
        FLUSH: state <= WAITBUF;
        WAITBUF: begin
          if (bus.VSTART) begin
            araddr_q  <= bus.DISPADDR;
            burst_cnt <= '0;
            state     <= FLUSH;
          end else if (!bus.DISPON) begin
            state <= HALT;
          end else if (bus.BUF_WREADY) begin
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (bus.VSTART) pending <= 1'b1;
          if (bus.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (last_beat) begin
            rready_q <= 1'b0;
            if (pending || bus.VSTART) begin
              araddr_q  <= bus.DISPADDR;
              burst_cnt <= '0;
              pending   <= 1'b0;
              state     <= FLUSH;
            end else begin
              araddr_q  <= araddr_q + STEP;
              burst_cnt <= cnt_inc;
              if (!bus.DISPON || cnt_inc == LAST_CNT) state <= HALT;
              else                                    state <= WAITBUF;
            end
          end else if (bus.VSTART) begin
            pending <= 1'b1;
          end
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_disp_fetch.sv
// tb/tb_disp_fetch.sv - directed self-checking bench for disp_fetch
`timescale 1ns/1ps
module tb_disp_fetch;
  // Reduced frame: 64x8 pixels -> 256 beats -> 16 bursts of 16 beats.
  localparam int HP = 64;
  localparam int VL = 8;
  localparam int BL = 16;
  localparam int BB = 8;
  localparam int NB = 16;
  localparam int FRAME_BEATS = 256;
  localparam logic [31:0] STEP = 32'h80;

  logic ACLK = 1'b0;
  logic ARST = 1'b1;
  disp_fetch_if bus();

  disp_fetch #(.H_PIXELS(HP), .V_LINES(VL), .BURST_LEN(BL), .BEAT_BYTES(BB)) dut (
    .ACLK(ACLK),
    .ARST(ARST),
    .bus (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          ar_stall = 0;
  bit          rv_toggle = 1'b0;
  int          stall_left = 0;
  bit          rv_phase = 1'b0;
  bit          burst_on = 1'b0;
  int          beat = 0;
  logic [31:0] burst_addr = '0;
  logic [63:0] exp_q[$];
  bit          wr_due = 1'b0;
  int          wr_cnt = 0;
  int          ar_cnt = 0;
  int          rst_cnt = 0;
  int          wr_at_rst = 0;
  int          ar_at_rst = 0;
  int          arv_cycles = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] next_base = '0;
  logic [31:0] last_ar_addr = '0;
  bit          prev_arv = 1'b0;
  bit          prev_hs = 1'b0;
  logic [31:0] prev_addr = '0;

  // One clock: observe outputs of the last edge, then drive the memory side for the next edge.
  task automatic tick();
    bit hs;
    bit acc;
    @(negedge ACLK);
    check("fifowr", bus.FIFOWR, wr_due);
    if (bus.FIFOWR) begin
      wr_cnt++;
      if (exp_q.size() > 0) check("fifoin", bus.FIFOIN, exp_q.pop_front());
      else                  check("fifoin_extra", 1'b1, 1'b0);
    end
    if (bus.FIFORST) begin
      rst_cnt++;
      wr_at_rst = wr_cnt;
      ar_at_rst = ar_cnt;
      exp_addr  = next_base;
      check("rst_vs_wr", bus.FIFOWR, 1'b0);
    end
    if (prev_arv && !prev_hs) begin
      check("arvalid_hold", bus.ARVALID, 1'b1);
      check("araddr_hold", bus.ARADDR, prev_addr);
    end
    if (bus.ARVALID) arv_cycles++;

    rv_phase   = ~rv_phase;
    bus.RVALID = burst_on && (!rv_toggle || rv_phase);
    bus.RDATA  = {burst_addr, 24'h5A0000, 8'(beat)};
    bus.RLAST  = burst_on && (beat == BL - 1);
    acc = bus.RVALID && bus.RREADY;
    if (acc) begin
      exp_q.push_back(bus.RDATA);
      beat++;
      if (beat == BL) burst_on = 1'b0;
    end
    wr_due = acc;

    if (bus.ARVALID && (!prev_arv || prev_hs)) stall_left = ar_stall;
    bus.ARREADY = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    hs = bus.ARVALID && bus.ARREADY;
    if (hs) begin
      check("one_outstanding", burst_on, 1'b0);
      check("araddr", bus.ARADDR, exp_addr);
      exp_addr     = exp_addr + STEP;
      last_ar_addr = bus.ARADDR;
      ar_cnt++;
      burst_on   = 1'b1;
      beat       = 0;
      burst_addr = bus.ARADDR;
    end
    prev_arv  = bus.ARVALID;
    prev_hs   = hs;
    prev_addr = bus.ARADDR;
  endtask

  task automatic pulse_vstart(input logic [31:0] base);
    bus.DISPADDR = base;
    next_base    = base;
    bus.VSTART   = 1'b1;
    tick();
    bus.VSTART   = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, wr_cnt >= target, 1'b1);
  endtask

  task automatic wait_ar(input int target, input int budget, input string tag);
    int n = 0;
    while (ar_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, ar_cnt >= target, 1'b1);
  endtask

  task automatic check_idle(input int cycles, input string tag);
    int a0 = arv_cycles;
    int w0 = wr_cnt;
    repeat (cycles) tick();
    check({tag, "_arvalid"}, arv_cycles - a0, 0);
    check({tag, "_fifowr"}, wr_cnt - w0, 0);
  endtask

  initial begin
    int wr0, ar0, rst0, arv0, n;

    bus.DISPON = 1'b0; bus.VSTART = 1'b0; bus.DISPADDR = '0; bus.BUF_WREADY = 1'b0;
    bus.ARREADY = 1'b0; bus.RDATA = '0; bus.RVALID = 1'b0; bus.RLAST = 1'b0;

    #2;
    check("rst_arvalid", bus.ARVALID, 1'b0);
    check("rst_rready", bus.RREADY, 1'b0);
    check("rst_fifowr", bus.FIFOWR, 1'b0);
    check("rst_fiforst", bus.FIFORST, 1'b0);
    check("rst_araddr", bus.ARADDR, 32'h0);
    check("rst_fifoin", bus.FIFOIN, 64'h0);
    check("arlen", bus.ARLEN, 8'd15);
    tick(); tick();
    ARST = 1'b0;
    tick();

    // Basic frame
    bus.DISPON = 1'b1; bus.BUF_WREADY = 1'b1;
    wr0 = wr_cnt; ar0 = ar_cnt; rst0 = rst_cnt;
    pulse_vstart(32'h1000_0000);
    wait_wr(wr0 + FRAME_BEATS, 1500, "basic_done");
    check("basic_bursts", ar_cnt - ar0, NB);
    check("basic_flush_cnt", rst_cnt - rst0, 1);
    check("basic_flush_first", wr_at_rst - wr0, 0);
    check("basic_last_addr", last_ar_addr, 32'h1000_0780);
    check_idle(30, "basic_halt");

    // Backpressure after the third burst
    wr0 = wr_cnt; ar0 = ar_cnt;
    pulse_vstart(32'h3000_0000);
    wait_ar(ar0 + 3, 200, "bp_third");
    bus.BUF_WREADY = 1'b0;
    arv0 = arv_cycles;
    repeat (50) tick();
    check("bp_no_arvalid", arv_cycles - arv0, 0);
    check("bp_bursts_held", ar_cnt - ar0, 3);
    bus.BUF_WREADY = 1'b1;
    wait_ar(ar0 + 4, 50, "bp_fourth");
    check("bp_fourth_addr", last_ar_addr, 32'h3000_0180);
    wait_wr(wr0 + FRAME_BEATS, 1500, "bp_done");
    check_idle(20, "bp_halt");

    // AXI stalls: ARREADY low 7 cycles, RVALID every other cycle
    ar_stall = 7; rv_toggle = 1'b1;
    wr0 = wr_cnt; ar0 = ar_cnt;
    pulse_vstart(32'h4000_0000);
    wait_ar(ar0 + 2, 200, "stall_second");
    check("stall_burst1_wr", wr_cnt - wr0, 16);
    wait_wr(wr0 + FRAME_BEATS, 3000, "stall_done");
    check("stall_bursts", ar_cnt - ar0, NB);
    check("stall_last_addr", last_ar_addr, 32'h4000_0780);
    check_idle(20, "stall_halt");
    ar_stall = 0; rv_toggle = 1'b0;

    // VSTART on beat 5 of burst 2
    wr0 = wr_cnt; ar0 = ar_cnt; rst0 = rst_cnt;
    pulse_vstart(32'h1000_0000);
    n = 0;
    while (!(ar_cnt == ar0 + 2 && beat >= 4) && n < 200) begin
      tick();
      n++;
    end
    check("mid_reach_beat5", (ar_cnt == ar0 + 2) && (beat >= 4), 1'b1);
    pulse_vstart(32'h2000_0000);
    n = 0;
    while (rst_cnt < rst0 + 2 && n < 100) begin
      tick();
      n++;
    end
    check("mid_flush_cnt", rst_cnt - rst0, 2);
    check("mid_drained", wr_at_rst - wr0, 32);
    check("mid_bursts_before", ar_at_rst - ar0, 2);
    wait_wr(wr_at_rst + FRAME_BEATS, 1500, "mid_new_frame");
    check("mid_new_bursts", ar_cnt - ar_at_rst, NB);
    check("mid_last_addr", last_ar_addr, 32'h2000_0780);
    check_idle(30, "mid_halt");

    // DISPON drop while ARREADY stalls in ADDR
    ar_stall = 4;
    wr0 = wr_cnt; ar0 = ar_cnt; arv0 = arv_cycles;
    pulse_vstart(32'h5000_0000);
    n = 0;
    while (arv_cycles == arv0 && n < 50) begin
      tick();
      n++;
    end
    bus.DISPON = 1'b0;
    wait_wr(wr0 + 16, 100, "drop_drained");
    check("drop_arvalid_cycles", arv_cycles - arv0, 5);
    check("drop_bursts", ar_cnt - ar0, 1);
    check_idle(40, "drop_halt");
    check("drop_total_wr", wr_cnt - wr0, 16);
    ar_stall = 0;
    bus.DISPON = 1'b1;

    // Reset during beat 9
    wr0 = wr_cnt; ar0 = ar_cnt;
    pulse_vstart(32'h6000_0000);
    n = 0;
    while (!(ar_cnt == ar0 + 1 && beat >= 9) && n < 100) begin
      tick();
      n++;
    end
    check("arst_reach_beat9", (ar_cnt == ar0 + 1) && (beat >= 9), 1'b1);
    ARST = 1'b1;
    #1;
    check("arst_arvalid", bus.ARVALID, 1'b0);
    check("arst_rready", bus.RREADY, 1'b0);
    check("arst_fifowr", bus.FIFOWR, 1'b0);
    check("arst_fiforst", bus.FIFORST, 1'b0);
    check("arst_araddr", bus.ARADDR, 32'h0);
    check("arst_fifoin", bus.FIFOIN, 64'h0);
    burst_on = 1'b0; beat = 0; exp_q.delete(); wr_due = 1'b0;
    prev_arv = 1'b0; prev_hs = 1'b0; stall_left = 0;
    bus.RVALID = 1'b0; bus.RLAST = 1'b0;
    tick();
    ARST = 1'b0;
    check_idle(30, "arst_quiet");
    wr0 = wr_cnt; rst0 = rst_cnt;
    pulse_vstart(32'h6000_0000);
    wait_wr(wr0 + 16, 100, "arst_restart");
    check("arst_restart_flush", rst_cnt - rst0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/disp_fetch.md
Name: disp_fetch

Overview:
- Read-side master that fills the display buffer from frame memory in DRAM.
- Issues fixed-length AXI4 read bursts over the framebuffer and pushes each returned 64-bit beat (two 24-bit pixels) into the display FIFO.
- Throttled by the buffer's BUF_WREADY; restarts at every frame start.
- Sits in the ACLK domain between the memory interconnect and the display buffer.

Parameters:
- H_PIXELS, 640, active pixels per line.
- V_LINES, 480, active lines per frame.
- BURST_LEN, 16, beats per AXI burst (ARLEN = BURST_LEN-1). H_PIXELS*V_LINES/2 must be a multiple of BURST_LEN.
- BEAT_BYTES, 8, bytes per beat (address step per beat).

Ports:
- ACLK  in  1  system clock; single clock domain.
- ARST  in  1  reset; asynchronous, active-high.
- DISPON  in  1  display enable; level.
- VSTART  in  1  one-cycle frame-start pulse, already synchronous to ACLK.
- DISPADDR  in  32  framebuffer base address; sampled on VSTART.
- BUF_WREADY  in  1  buffer has room for at least one full burst.
- FIFORST  out  1  buffer flush pulse.
- FIFOIN  out  64  pixel pair: [55:32] = first pixel, [23:0] = second pixel; upper bytes pass through.
- FIFOWR  out  1  FIFO write strobe.
- ARADDR  out  32  AXI read address.
- ARLEN  out  8  constant BURST_LEN-1.
- ARVALID  out  1  AXI read address valid.
- ARREADY  in  1  AXI read address ready.
- RDATA  in  64  AXI read data.
- RVALID  in  1  AXI read data valid.
- RLAST  in  1  last beat of a burst.
- RREADY  out  1  AXI read data ready.

Behaviour:
- Reset values: state HALT; ARVALID=0, RREADY=0, FIFOWR=0, FIFORST=0, ARADDR=0, FIFOIN=0; burst counter 0; pending-restart flag 0.
- Derived constants:
  - WORDS = H_PIXELS*V_LINES/2.
  - NBURST = WORDS/BURST_LEN (9600 at defaults).
  - STEP = BURST_LEN*BEAT_BYTES (128 bytes).
- States: HALT, FLUSH, WAITBUF, ADDR, DATA.
- HALT:
  - VSTART and DISPON both high -> latch DISPADDR into ARADDR, clear burst counter, go FLUSH.
  - Otherwise stay.
- FLUSH: drive FIFORST=1 for exactly one cycle, then go WAITBUF.
- WAITBUF:
  - DISPON=0 -> HALT.
  - BUF_WREADY=1 -> ADDR.
- ADDR:
  - Hold ARVALID=1 with ARADDR stable until ARREADY is sampled high.
  - On the handshake cycle, deassert ARVALID and go DATA.
  - ARVALID is never withdrawn before the handshake, even if DISPON falls.
- DATA:
  - RREADY=1 throughout.
  - Each cycle with RVALID&RREADY: FIFOWR=1 and FIFOIN=RDATA, registered with one-cycle latency.
  - On the RLAST beat: ARADDR += STEP, burst counter += 1, then:
    - pending flag or VSTART this cycle -> latch DISPADDR, clear counter and flag, go FLUSH;
    - else DISPON=0 -> HALT;
    - else counter reaches NBURST -> HALT (wait for next VSTART);
    - else -> WAITBUF.
- VSTART in WAITBUF: latch DISPADDR, clear counter, go FLUSH. Any burst already in flight completes first (the ADDR/DATA rules apply).
- VSTART in ADDR or DATA (not the RLAST cycle): set the pending flag. The outstanding burst is always fully drained; beats from the old frame are still written to the FIFO, then flushed.
- FLUSH sequencing: FIFORST is never asserted in the same cycle as FIFOWR. The last FIFOWR of the old frame precedes FIFORST by at least one cycle.
- Widths and address arithmetic:
  - ARADDR wraps modulo 2^32.
  - No 4 KB-crossing check; DISPADDR must be STEP-aligned.
  - Burst counter width is clog2(NBURST+1).
- Only one burst is outstanding at a time.
- Beats arriving while RREADY=0 are not accepted (protocol compliance).
- ARST at any time: immediate return to reset values. The memory side is reset by the same ARST.

Test Plan:
- Basic frame:
  - Stimulus: DISPADDR=0x1000_0000, DISPON=1, VSTART pulse, BUF_WREADY=1, ARREADY and RVALID always 1.
  - Response: one FIFORST pulse, then 9600 bursts at 0x1000_0000, 0x1000_0080, ...; last ARADDR 0x1012_BF80; 153600 FIFOWR strobes; then HALT.
- Backpressure:
  - Stimulus: BUF_WREADY=0 for 50 cycles after burst 3.
  - Response: no ARVALID during those cycles; the fourth ARADDR is base+0x180 once BUF_WREADY returns to 1.
- AXI stalls:
  - Stimulus: ARREADY low for 7 cycles, RVALID toggled every other cycle.
  - Response: ARADDR/ARVALID stable for all 7 cycles; exactly 16 FIFOWR per burst; FIFOIN equals RDATA order.
- Mid-burst VSTART:
  - Stimulus: VSTART on beat 5 of burst 2, with DISPADDR=0x2000_0000.
  - Response: remaining 11 beats written; then FIFORST; next ARADDR 0x2000_0000; counter restarts at 0.
- DISPON drop:
  - Stimulus: DISPON=0 during ADDR with ARREADY held low 4 cycles.
  - Response: ARVALID held until handshake, burst fully drained, then HALT with no further ARVALID.
- Reset mid-burst:
  - Stimulus: ARST asserted during DATA beat 9.
  - Response: all outputs at reset values in the same cycle; no FIFOWR until a new VSTART.
